change_dispenser: RTL

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/change_dispenser_pkg.sv | 43 ++++
 rtl/denom_select.sv | 33 +++
 rtl/change_dispenser.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the change dispenser: FSM states, denomination codes and values, error codes.
// Denomination index i always matches bit i of the one-hot code.
package change_dispenser_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_SELECT,
        ST_DISPENSE,
        ST_DONE
    } state_e;

    localparam int NUM_DENOM = 4;

    localparam logic [3:0] DENOM_NONE = 4'b0000;
    localparam logic [3:0] DENOM_500  = 4'b0001;
    localparam logic [3:0] DENOM_1000 = 4'b0010;
    localparam logic [3:0] DENOM_2000 = 4'b0100;
    localparam logic [3:0] DENOM_5000 = 4'b1000;

    localparam logic [15:0] VAL_500  = 16'd500;
    localparam logic [15:0] VAL_1000 = 16'd1000;
    localparam logic [15:0] VAL_2000 = 16'd2000;
    localparam logic [15:0] VAL_5000 = 16'd5000;

    localparam logic [3:0] ERR_OK       = 4'b0000;
    localparam logic [3:0] ERR_NOT_MULT = 4'b0001;
    localparam logic [3:0] ERR_NO_STOCK = 4'b0010;
    localparam logic [3:0] ERR_TIMEOUT  = 4'b0100;

    function automatic logic [15:0] denom_value(input logic [3:0] code);
        logic [15:0] v;
        case (code)
            DENOM_500:  v = VAL_500;
            DENOM_1000: v = VAL_1000;
            DENOM_2000: v = VAL_2000;
            DENOM_5000: v = VAL_5000;
            default:    v = 16'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/denom_select.sv
// Greedy denomination picker: largest note not above the amount owed that is still in stock.
// Purely combinational; found_o low means nothing fits.
module denom_select
    import change_dispenser_pkg::*;
(
    input  logic [15:0] remaining_i,
    input  logic [7:0]  inv_500_i,
    input  logic [7:0]  inv_1000_i,
    input  logic [7:0]  inv_2000_i,
    input  logic [7:0]  inv_5000_i,
    output logic [3:0]  denom_o,
    output logic        found_o
);

    always_comb begin
        denom_o = DENOM_NONE;
        found_o = 1'b0;
        if (remaining_i >= VAL_5000 && inv_5000_i != 8'd0) begin
            denom_o = DENOM_5000;
            found_o = 1'b1;
        end else if (remaining_i >= VAL_2000 && inv_2000_i != 8'd0) begin
            denom_o = DENOM_2000;
            found_o = 1'b1;
        end else if (remaining_i >= VAL_1000 && inv_1000_i != 8'd0) begin
            denom_o = DENOM_1000;
            found_o = 1'b1;
        end else if (remaining_i >= VAL_500 && inv_500_i != 8'd0) begin
            denom_o = DENOM_500;
            found_o = 1'b1;
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays out an amount note by note with a valid/ack handshake to the mechanism.
// dispense_valid/dispense_type are registered; an item counts only on the edge where ack is seen high.
module change_dispenser
    import change_dispenser_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] change_amount,
    input  logic [7:0]  avail_500,
    input  logic [7:0]  avail_1000,
    input  logic [7:0]  avail_2000,
    input  logic [7:0]  avail_5000,
    input  logic        dispense_ack,
    output logic        dispense_valid,
    output logic [3:0]  dispense_type,
    output logic        busy,
    output logic        done,
    output logic [3:0]  error,
    output logic [15:0] remaining,
    output logic [7:0]  out_500,
    output logic [7:0]  out_1000,
    output logic [7:0]  out_2000,
    output logic [7:0]  out_5000
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(ACK_TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [15:0]     remaining_q, remaining_d;
    logic [7:0]      inv_q [NUM_DENOM];
    logic [7:0]      inv_d [NUM_DENOM];
    logic [7:0]      out_q [NUM_DENOM];
    logic [7:0]      out_d [NUM_DENOM];
    logic [7:0]      avail [NUM_DENOM];
    logic [3:0]      error_q, error_d;
    logic [3:0]      type_q, type_d;
    logic            valid_q, valid_d;
    logic [CW-1:0]   to_cnt_q, to_cnt_d;
    logic [3:0]      sel_denom;
    logic            sel_found;

    assign avail[0] = avail_500;
    assign avail[1] = avail_1000;
    assign avail[2] = avail_2000;
    assign avail[3] = avail_5000;

    denom_select u_denom_select (
        .remaining_i (remaining_q),
        .inv_500_i   (inv_q[0]),
        .inv_1000_i  (inv_q[1]),
        .inv_2000_i  (inv_q[2]),
        .inv_5000_i  (inv_q[3]),
        .denom_o     (sel_denom),
        .found_o     (sel_found)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            remaining_q <= 16'd0;
            error_q     <= ERR_OK;
            type_q      <= DENOM_NONE;
            valid_q     <= 1'b0;
            to_cnt_q    <= '0;
            for (int i = 0; i < NUM_DENOM; i++) begin
                inv_q[i] <= 8'd0;
                out_q[i] <= 8'd0;
            end
        end else begin
            remaining_q <= remaining_d;
            error_q     <= error_d;
            type_q      <= type_d;
            valid_q     <= valid_d;
            to_cnt_q    <= to_cnt_d;
            for (int i = 0; i < NUM_DENOM; i++) begin
                inv_q[i] <= inv_d[i];
                out_q[i] <= out_d[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        error_d     = error_q;
        type_d      = type_q;
        valid_d     = valid_q;
        to_cnt_d    = to_cnt_q;
        inv_d       = inv_q;
        out_d       = out_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    remaining_d = change_amount;
                    error_d     = ERR_OK;
                    for (int i = 0; i < NUM_DENOM; i++) begin
                        inv_d[i] = avail[i];
                        out_d[i] = 8'd0;
                    end
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if ((remaining_q % VAL_500) != 16'd0) begin
                    error_d = ERR_NOT_MULT;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (remaining_q == 16'd0) begin
                    state_d = ST_DONE;
                end else if (sel_found) begin
                    type_d   = sel_denom;
                    valid_d  = 1'b1;
                    to_cnt_d = '0;
                    state_d  = ST_DISPENSE;
                end else begin
                    error_d = ERR_NO_STOCK;
                    state_d = ST_DONE;
                end
            end
            ST_DISPENSE: begin
                if (dispense_ack) begin
                    remaining_d = remaining_q - denom_value(type_q);
                    for (int i = 0; i < NUM_DENOM; i++) begin
                        if (type_q[i]) begin
                            out_d[i] = out_q[i] + 8'd1;
                            inv_d[i] = inv_q[i] - 8'd1;
                        end
                    end
                    valid_d = 1'b0;
                    type_d  = DENOM_NONE;
                    state_d = ST_SELECT;
                end else if (to_cnt_q == TO_LAST) begin
                    // The item was never taken, so nothing is counted as paid out.
                    error_d = ERR_TIMEOUT;
                    valid_d = 1'b0;
                    type_d  = DENOM_NONE;
                    state_d = ST_DONE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        busy = (state_q != ST_IDLE);
        done = (state_q == ST_DONE);
    end

    assign dispense_valid = valid_q;
    assign dispense_type  = type_q;
    assign error          = error_q;
    assign remaining      = remaining_q;
    assign out_500        = out_q[0];
    assign out_1000       = out_q[1];
    assign out_2000       = out_q[2];
    assign out_5000       = out_q[3];

endmodule
